// File: rtl/move_queue_sequencer_pkg.sv
// Shared cube definitions: move codes, face indices, FSM state types and
// the inverse-move test used by the move queue sequencer.
package cube_pkg;

  // Move codes. Each face owns an even/odd pair; the odd code is the inverse turn.
  typedef enum logic [3:0] {
    MV_NOP0 = 4'd0,
    MV_NOP1 = 4'd1,
    MV_R    = 4'd2,
    MV_RI   = 4'd3,
    MV_U    = 4'd4,
    MV_UI   = 4'd5,
    MV_F    = 4'd6,
    MV_FI   = 4'd7,
    MV_L    = 4'd8,
    MV_LI   = 4'd9,
    MV_B    = 4'd10,
    MV_BI   = 4'd11,
    MV_D    = 4'd12,
    MV_DI   = 4'd13
  } move_t;

  // Face index of a move code is (code >> 1) - 1.
  localparam int unsigned RIGHT = 0;
  localparam int unsigned UP    = 1;
  localparam int unsigned FRONT = 2;
  localparam int unsigned LEFT  = 3;
  localparam int unsigned BACK  = 4;
  localparam int unsigned DOWN  = 5;

  typedef enum logic {
    U_IDLE,
    U_SCAN
  } unpack_state_t;

  typedef enum logic {
    E_IDLE,
    E_WAIT
  } exec_state_t;

  // Same face, opposite direction; padding codes never count as inverses.
  function automatic logic is_inverse(input logic [3:0] a, input logic [3:0] b);
    return (a[3:1] == b[3:1]) && (a[0] != b[0]) && (a[3:1] != 3'd0);
  endfunction

endpackage

// File: rtl/move_queue_sequencer_fifo.sv
// Synchronous move FIFO with head pop, tail pop (for inverse cancellation)
// and an occupancy count. Pointers carry one extra wrap bit.
module move_fifo #(
  parameter int unsigned W     = 4,
  parameter int unsigned DEPTH = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic [W-1:0]            data_in,
  input  logic                    pop,
  input  logic                    pop_tail,
  output logic [W-1:0]            head,
  output logic [W-1:0]            tail,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] tail_idx;

  assign tail_idx = wr_ptr[AW-1:0] - AW'(1);
  assign head     = mem[rd_ptr[AW-1:0]];
  assign tail     = mem[tail_idx];
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Pointer update: push advances, tail pop retracts the write pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !pop_tail)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      else if (pop_tail && !push)
        wr_ptr <= wr_ptr - (AW+1)'(1);
      if (pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate every read.
  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= data_in;
  end

endmodule

// File: rtl/move_queue_sequencer.sv
// Move queue sequencer: unpacks move batches into a FIFO (cancelling
// adjacent inverse pairs on entry) and feeds them one at a time to the
// stepper over the move_start/move_done handshake.
module move_queue_sequencer
  import cube_pkg::*;
#(
  parameter int unsigned MOVE_W      = 4,
  parameter int unsigned BATCH_MOVES = 50,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned STREAM      = 0,
  parameter int unsigned CANCEL_INV  = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          load_valid,
  input  logic [MOVE_W*BATCH_MOVES-1:0] load_moves,
  output logic                          load_ready,
  input  logic                          seq_complete,
  input  logic                          pause,
  output logic [MOVE_W-1:0]             next_move,
  output logic                          move_start,
  input  logic                          move_done,
  output logic [$clog2(DEPTH+1)-1:0]    pending,
  output logic [7:0]                    executed,
  output logic                          busy,
  output logic                          overflow,
  output logic                          seq_done
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = (BATCH_MOVES > 1) ? $clog2(BATCH_MOVES) : 1;
  localparam int unsigned BW = MOVE_W * BATCH_MOVES;

  unpack_state_t u_state, u_next;
  exec_state_t   e_state, e_next;

  logic [BW-1:0]     batch;
  logic [SW-1:0]     slot;
  logic [MOVE_W-1:0] code;
  logic              scanning;
  logic              accept;
  logic              last_slot;

  logic [MOVE_W-1:0] head;
  logic [MOVE_W-1:0] tail;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;

  logic slot_live;
  logic tail_inv;
  logic do_cancel;
  logic do_push;
  logic drop;
  logic issue;
  logic complete;
  logic done_latch;
  logic fire;

  move_fifo #(
    .W     (MOVE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (do_push),
    .data_in  (code),
    .pop      (issue),
    .pop_tail (do_cancel),
    .head     (head),
    .tail     (tail),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign pending   = count;
  assign code      = batch[BW-1 -: MOVE_W];
  assign last_slot = (slot == SW'(BATCH_MOVES-1));

  // Unpacker state register.
  always_ff @(posedge clock) begin
    if (reset) u_state <= U_IDLE;
    else       u_state <= u_next;
  end

  // Unpacker next state: one slot per cycle, back to idle after the last one.
  always_comb begin
    u_next = u_state;
    unique case (u_state)
      U_IDLE: if (load_valid) u_next = U_SCAN;
      U_SCAN: if (last_slot)  u_next = U_IDLE;
      default: u_next = U_IDLE;
    endcase
  end

  // Unpacker outputs.
  always_comb begin
    load_ready = (u_state == U_IDLE);
    scanning   = (u_state == U_SCAN);
    accept     = load_ready && load_valid;
  end

  // Batch shift register: the current slot always sits in the MSBs.
  always_ff @(posedge clock) begin
    if (reset) begin
      batch <= '0;
      slot  <= '0;
    end else if (accept) begin
      batch <= load_moves;
      slot  <= '0;
    end else if (scanning) begin
      batch <= batch << MOVE_W;
      slot  <= slot + SW'(1);
    end
  end

  // Entry decision for the current slot. An issue that empties the queue in
  // the same cycle wins over a cancel, so the candidate is pushed instead.
  always_comb begin
    slot_live = scanning && (code >= MOVE_W'(MV_R));
    tail_inv  = (tail[MOVE_W-1:1] == code[MOVE_W-1:1]) && (tail[0] != code[0]);
    do_cancel = slot_live && (CANCEL_INV != 0) && !empty && tail_inv
                && !(issue && (count == CW'(1)));
    do_push   = slot_live && !do_cancel && !full;
    drop      = slot_live && !do_cancel && full;
  end

  // Executor state register.
  always_ff @(posedge clock) begin
    if (reset) e_state <= E_IDLE;
    else       e_state <= e_next;
  end

  // Executor next state: issue from idle, wait for the stepper to finish.
  always_comb begin
    e_next = e_state;
    unique case (e_state)
      E_IDLE: if (issue)     e_next = E_WAIT;
      E_WAIT: if (move_done) e_next = E_IDLE;
      default: e_next = E_IDLE;
    endcase
  end

  // Executor outputs and completion condition.
  always_comb begin
    busy     = (e_state == E_WAIT);
    issue    = (e_state == E_IDLE) && !empty && !pause && ((STREAM != 0) || done_latch);
    complete = (e_state == E_WAIT) && move_done;
    fire     = done_latch && (u_state == U_IDLE) && empty && (e_state == E_IDLE);
  end

  // Issue register, saturating completion counter, sticky overflow and completion latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      next_move  <= '0;
      move_start <= 1'b0;
      executed   <= '0;
      overflow   <= 1'b0;
      done_latch <= 1'b0;
      seq_done   <= 1'b0;
    end else begin
      move_start <= issue;
      if (issue)
        next_move <= head;
      if (complete && (executed != 8'hFF))
        executed <= executed + 8'd1;
      if (drop)
        overflow <= 1'b1;
      seq_done <= fire;
      if (seq_complete)
        done_latch <= 1'b1;
      else if (fire)
        done_latch <= 1'b0;
    end
  end

endmodule

// File: tb/tb_move_queue_sequencer.sv
// Testbench for move_queue_sequencer: three instances (deferred, streaming,
// shallow without cancellation) checked against a queue-based reference.
module tb_move_queue_sequencer;

  localparam int NI  = 3;
  localparam int BM  = 50;
  localparam int BW  = 4 * BM;
  localparam int DLY = 10;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic           reset;
  logic [NI-1:0]  load_valid;
  logic [BW-1:0]  load_moves [NI];
  logic [NI-1:0]  load_ready;
  logic [NI-1:0]  seq_complete;
  logic [NI-1:0]  pause;
  logic [3:0]     next_move [NI];
  logic [NI-1:0]  move_start;
  logic [NI-1:0]  move_done;
  logic [NI-1:0]  step_done;
  logic [NI-1:0]  extra_done;
  logic [6:0]     pending [NI];
  logic [7:0]     executed [NI];
  logic [NI-1:0]  busy;
  logic [NI-1:0]  overflow;
  logic [NI-1:0]  seq_done;

  assign move_done = step_done | extra_done;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int unsigned DEP = (g == 2) ? 4 : 64;
    localparam int unsigned STR = (g == 1) ? 1 : 0;
    localparam int unsigned CAN = (g == 2) ? 0 : 1;
    logic [$clog2(DEP+1)-1:0] pend_w;
    move_queue_sequencer #(
      .MOVE_W      (4),
      .BATCH_MOVES (BM),
      .DEPTH       (DEP),
      .STREAM      (STR),
      .CANCEL_INV  (CAN)
    ) dut (
      .clock        (clock),
      .reset        (reset),
      .load_valid   (load_valid[g]),
      .load_moves   (load_moves[g]),
      .load_ready   (load_ready[g]),
      .seq_complete (seq_complete[g]),
      .pause        (pause[g]),
      .next_move    (next_move[g]),
      .move_start   (move_start[g]),
      .move_done    (move_done[g]),
      .pending      (pend_w),
      .executed     (executed[g]),
      .busy         (busy[g]),
      .overflow     (overflow[g]),
      .seq_done     (seq_done[g])
    );
    assign pending[g] = 7'(pend_w);
  end

  // Stepper model and issue/completion log, all sampled on the falling edge.
  logic [3:0] log_mv [NI][512];
  int         log_n  [NI];
  int         sd_cnt [NI];
  int         cnt    [NI];

  always @(negedge clock) begin
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        cnt[i]       = 0;
        step_done[i] = 1'b0;
        log_n[i]     = 0;
        sd_cnt[i]    = 0;
      end else begin
        step_done[i] = 1'b0;
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) step_done[i] = 1'b1;
        end
        if (move_start[i]) begin
          if (log_n[i] < 512) log_mv[i][log_n[i]] = next_move[i];
          log_n[i]++;
          cnt[i] = DLY;
        end
        if (seq_done[i]) sd_cnt[i]++;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: the queue of moves that will be issued, in order.
  int mq[$];
  bit movf;

  function automatic void model_clear();
    mq.delete();
    movf = 1'b0;
  endfunction

  function automatic void model_batch(input logic [BW-1:0] w, input int depth, input bit cancel);
    for (int s = BM - 1; s >= 0; s--) begin
      int c;
      c = int'(w[s*4 +: 4]);
      if (c < 2) continue;
      if (cancel && mq.size() > 0 && (mq[$] / 2 == c / 2) && (mq[$] != c))
        void'(mq.pop_back());
      else if (mq.size() == depth)
        movf = 1'b1;
      else
        mq.push_back(c);
    end
  endfunction

  function automatic logic [BW-1:0] mk(input int codes[$]);
    logic [BW-1:0] w;
    w = '0;
    for (int k = 0; k < codes.size(); k++)
      w[(BM-1-k)*4 +: 4] = 4'(codes[k]);
    return w;
  endfunction

  function automatic logic [BW-1:0] rnd_word();
    logic [BW-1:0] w;
    int prev;
    int c;
    int r;
    w = '0;
    prev = -1;
    for (int s = BM - 1; s >= 0; s--) begin
      r = int'($urandom_range(0, 99));
      if (r < 20)                   c = int'($urandom_range(0, 1));
      else if (r < 45 && prev >= 2) c = prev ^ 1;
      else                          c = int'($urandom_range(2, 15));
      if (c >= 2) prev = c;
      w[s*4 +: 4] = 4'(c);
    end
    return w;
  endfunction

  function automatic int depth_of(input int i);
    return (i == 2) ? 4 : 64;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    load_valid = '0;
    seq_complete = '0;
    pause = '0;
    extra_done = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic check_idle_outputs(input string tag, input int i);
    check({tag, "_rdy"},  32'(load_ready[i]), 1);
    check({tag, "_nm"},   32'(next_move[i]),  0);
    check({tag, "_ms"},   32'(move_start[i]), 0);
    check({tag, "_pend"}, 32'(pending[i]),    0);
    check({tag, "_exe"},  32'(executed[i]),   0);
    check({tag, "_busy"}, 32'(busy[i]),       0);
    check({tag, "_ovf"},  32'(overflow[i]),   0);
    check({tag, "_sd"},   32'(seq_done[i]),   0);
  endtask

  task automatic wait_scan(input int i);
    int wt;
    wt = 0;
    while (!load_ready[i] && wt < 200) begin
      @(negedge clock);
      wt++;
    end
    if (!load_ready[i]) check("scan_timeout", 0, 1);
  endtask

  task automatic send_batch(input int i, input logic [BW-1:0] w);
    wait_scan(i);
    load_moves[i] = w;
    load_valid[i] = 1'b1;
    @(negedge clock);
    load_valid[i] = 1'b0;
  endtask

  // After all batches are in: pulse seq_complete and compare the whole run.
  task automatic finish_deferred(input int i, input string tag);
    int wt;
    int n;
    check({tag, "_pend"}, 32'(pending[i]), 32'(mq.size()));
    check({tag, "_ovf"},  32'(overflow[i]), 32'(movf));
    repeat (10) @(negedge clock);
    check({tag, "_early"}, 32'(log_n[i]), 0);
    seq_complete[i] = 1'b1;
    @(negedge clock);
    seq_complete[i] = 1'b0;
    wt = 0;
    while (sd_cnt[i] == 0 && wt < 5000) begin
      @(negedge clock);
      wt++;
    end
    if (sd_cnt[i] == 0) check({tag, "_sd_timeout"}, 0, 1);
    repeat (5) @(negedge clock);
    check({tag, "_sdn"}, 32'(sd_cnt[i]), 1);
    check({tag, "_n"},   32'(log_n[i]), 32'(mq.size()));
    n = (log_n[i] < mq.size()) ? log_n[i] : mq.size();
    for (int k = 0; k < n; k++)
      check({tag, "_mv"}, 32'(log_mv[i][k]), 32'(mq[k]));
    check({tag, "_exe"},  32'(executed[i]), 32'((mq.size() > 255) ? 255 : mq.size()));
    check({tag, "_pend0"}, 32'(pending[i]), 0);
    check({tag, "_busy0"}, 32'(busy[i]), 0);
  endtask

  task automatic run_fixed(input int i, input int codes[$], input string tag);
    logic [BW-1:0] w;
    do_reset();
    model_clear();
    w = mk(codes);
    send_batch(i, w);
    model_batch(w, depth_of(i), i != 2);
    wait_scan(i);
    finish_deferred(i, tag);
  endtask

  task automatic wait_cond_exec(input int i, input int target, input int bound, input string tag);
    int wt;
    wt = 0;
    while (executed[i] != 8'(target) && wt < bound) begin
      @(negedge clock);
      wt++;
    end
    if (executed[i] != 8'(target)) check({tag, "_timeout"}, 32'(executed[i]), 32'(target));
  endtask

  initial begin
    int q[$];
    logic [BW-1:0] w1;
    logic [BW-1:0] w2;
    int lowc;
    int wt;
    int ls;

    reset = 1'b1;
    load_valid = '0;
    seq_complete = '0;
    pause = '0;
    extra_done = '0;
    for (int i = 0; i < NI; i++) load_moves[i] = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < NI; i++) check_idle_outputs("rst", i);

    // seq_complete with an empty queue: seq_done two cycles later.
    seq_complete[0] = 1'b1;
    @(negedge clock);
    seq_complete[0] = 1'b0;
    check("empty_sd_c1", 32'(seq_done[0]), 0);
    @(negedge clock);
    check("empty_sd_c2", 32'(seq_done[0]), 1);
    @(negedge clock);
    check("empty_sd_c3", 32'(seq_done[0]), 0);

    // Deferred ordering, cancellation, no-cancel and overflow.
    q = {2, 4, 3, 5};          run_fixed(0, q, "defer");
    q = {2, 4, 5, 3, 6};       run_fixed(0, q, "cancel");
    q = {2, 3, 4, 5};          run_fixed(2, q, "nocancel");
    q = {2, 4, 6, 8, 10, 12};  run_fixed(2, q, "ovf");

    // Back-to-back batches with load_valid held through the scan.
    do_reset();
    model_clear();
    w1 = rnd_word();
    w2 = rnd_word();
    model_batch(w1, 64, 1'b1);
    model_batch(w2, 64, 1'b1);
    load_moves[0] = w1;
    load_valid[0] = 1'b1;
    @(negedge clock);
    load_moves[0] = w2;
    lowc = 0;
    while (!load_ready[0] && lowc < 100) begin
      lowc++;
      @(negedge clock);
    end
    check("b2b_ready_low", 32'(lowc), 50);
    @(negedge clock);
    load_valid[0] = 1'b0;
    check("b2b_accept2", 32'(load_ready[0]), 0);
    wait_scan(0);
    finish_deferred(0, "b2b");

    // Randomized deferred runs on the deep and the shallow instance.
    for (int r = 0; r < 6; r++) begin
      int nb;
      do_reset();
      model_clear();
      nb = int'($urandom_range(1, 2));
      for (int b = 0; b < nb; b++) begin
        w1 = rnd_word();
        send_batch(0, w1);
        model_batch(w1, 64, 1'b1);
      end
      wait_scan(0);
      finish_deferred(0, "rnd");
    end
    for (int r = 0; r < 3; r++) begin
      do_reset();
      model_clear();
      w1 = rnd_word();
      send_batch(2, w1);
      model_batch(w1, 4, 1'b0);
      wait_scan(2);
      finish_deferred(2, "rnd4");
    end

    // Streaming pause: the in-flight move completes, nothing new issues.
    do_reset();
    q = {2, 4, 6};
    send_batch(1, mk(q));
    wt = 0;
    while (!busy[1] && wt < 100) begin
      @(negedge clock);
      wt++;
    end
    check("pause_first_issue", 32'(busy[1]), 1);
    pause[1] = 1'b1;
    wt = 0;
    while (busy[1] && wt < 100) begin
      @(negedge clock);
      wt++;
    end
    check("pause_inflight_done", 32'(executed[1]), 1);
    ls = log_n[1];
    repeat (30) @(negedge clock);
    check("pause_hold", 32'(log_n[1]), 32'(ls));
    check("pause_busy", 32'(busy[1]), 0);
    check("pause_pend", 32'(pending[1]), 2);
    pause[1] = 1'b0;
    wait_cond_exec(1, 3, 300, "pause_resume");
    check("pause_n", 32'(log_n[1]), 3);
    for (int k = 0; k < 3; k++)
      check("pause_mv", 32'(log_mv[1][k]), 32'(q[k]));

    // Reset while a move is in flight with three queued behind it.
    do_reset();
    q = {2, 4, 6, 8};
    send_batch(1, mk(q));
    wt = 0;
    while (!(busy[1] && pending[1] == 7'd3) && wt < 100) begin
      @(negedge clock);
      wt++;
    end
    check("rstmid_setup", 32'(pending[1]), 3);
    reset = 1'b1;
    @(negedge clock);
    check_idle_outputs("rstmid", 1);
    reset = 1'b0;
    @(negedge clock);
    extra_done[1] = 1'b1;
    @(negedge clock);
    extra_done[1] = 1'b0;
    repeat (20) @(negedge clock);
    check("rstmid_exe", 32'(executed[1]), 0);
    check("rstmid_busy", 32'(busy[1]), 0);
    check("rstmid_issues", 32'(log_n[1]), 0);

    // Saturation of the executed counter in streaming mode.
    do_reset();
    w1 = '0;
    for (int s = 0; s < BM; s++) w1[s*4 +: 4] = 4'd2;
    for (int b = 0; b < 6; b++) begin
      send_batch(1, w1);
      wt = 0;
      while (!(load_ready[1] && pending[1] == 7'd0 && !busy[1]) && wt < 1500) begin
        @(negedge clock);
        wt++;
      end
      if (wt >= 1500) check("sat_drain_timeout", 0, 1);
    end
    check("sat_exe", 32'(executed[1]), 255);
    check("sat_n", 32'(log_n[1]), 300);
    check("sat_ovf", 32'(overflow[1]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/move_queue_sequencer.md
Name: move_queue_sequencer

Overview:
- Parametrised successor to the single-shot move sequencer.
- Accepts packed move batches from solving_algorithm, unpacks them into a FIFO and cancels adjacent inverse pairs (X then Xi) on entry.
- Issues moves one at a time to move_to_step using the move_start/move_done handshake.
- Supports deferred mode (run after seq_complete) or streaming mode, plus pause, overflow flagging and a completion pulse.

Parameters:
MOVE_W, 4, bits per move code; codes 0 and 1 are padding/no-op.
BATCH_MOVES, 50, move slots per load_moves word.
DEPTH, 64, FIFO entries; power of two.
STREAM, 0, 0 = hold execution until seq_complete seen; 1 = execute as soon as the queue is non-empty.
CANCEL_INV, 1, 1 = enable inverse-pair cancellation against the queue tail.

Ports:
clock  in  1  system clock (25 MHz domain)
reset  in  1  synchronous, active-high
load_valid  in  1  batch present on load_moves
load_moves  in  MOVE_W*BATCH_MOVES  packed batch; slot BATCH_MOVES-1 (MSBs) is the first move
load_ready  out  1  high when the unpacker is idle; batch accepted on load_valid&&load_ready
seq_complete  in  1  pulse: no further batches will arrive
pause  in  1  level; blocks new issues
next_move  out  MOVE_W  move code to the stepper; stable from move_start until move_done
move_start  out  1  one-cycle issue pulse
move_done  in  1  pulse from move_to_step when the turn is finished
pending  out  $clog2(DEPTH+1)  queued, not-yet-issued moves
executed  out  8  moves completed since reset; saturates at 255
busy  out  1  move in flight
overflow  out  1  sticky: a move was dropped because the FIFO was full
seq_done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: load_ready=1, next_move=0, move_start=0, pending=0, executed=0, busy=0, overflow=0, seq_done=0. Reset also clears FIFO pointers, the completion latch and both FSMs, and aborts any in-flight move: the bench drives move_done low, and a later move_done is ignored.
- Unpacker FSM, U_IDLE -> U_SCAN -> U_IDLE:
  - On accept, latch the word and drop load_ready.
  - Scan one slot per cycle, MSB slot first; exactly BATCH_MOVES cycles.
  - Slots with code < 2 are skipped.
  - Return to U_IDLE (load_ready=1) on the cycle after the last slot.
- Per slot with code >= 2:
  - If CANCEL_INV=1, pending>0, and the tail entry satisfies tail[MOVE_W-1:1]==code[MOVE_W-1:1] with tail[0]!=code[0]: pop the tail (wr_ptr-1) and do not push.
  - Otherwise push.
  - If the FIFO is full: drop the move and set overflow.
- Issue and push in the same cycle are legal; pending is updated by the net result.
- If issue removes the only entry in the same cycle as a cancel candidate arrives, there is no cancel: the candidate is pushed.
- Executor FSM:
  - E_IDLE: issue when pending>0, !pause, and (STREAM or the completion latch is set). On issue:
    - next_move <= head;
    - move_start pulses one cycle;
    - head is popped;
    - busy=1;
    - -> E_WAIT.
  - E_WAIT: on move_done -> busy=0, executed++ (saturating), -> E_IDLE.
  - Issue-to-issue minimum: 2 cycles after move_done.
- pause only blocks transitions out of E_IDLE; an in-flight move completes normally.
- Completion latch: set by seq_complete, including while the unpacker is scanning.
- seq_done fires for one cycle when all of these hold: latch set, unpacker in U_IDLE, pending==0, executor in E_IDLE. The latch then clears.
- A seq_complete with nothing queued produces seq_done 2 cycles later.
- FIFO pointers are $clog2(DEPTH)+1 bits wide; full/empty come from MSB comparison, and wrap-around is natural.

Decomposition:
- Shared package (cube_pkg): move codes R..Di, the padding codes, a function is_inverse(a,b), and face-index constants (RIGHT..DOWN).
- One sub-module, move_fifo: synchronous FIFO with push, pop and pop_tail, tail/head read, and count.
- The unpacker and executor FSMs stay in the top module.

Test Plan:
- Deferred mode, load {…0,R,U,Ri,Ui}, then seq_complete; stepper model answers done 10 cycles after each start. Expected: four move_start pulses carrying 2, 4, 3, 5 in that order, executed=4, one seq_done pulse, no issue before seq_complete.
- Cancellation: load {R,U,Ui,Ri,F}. Expected: pending=1 after the scan, single issue of F (6). With CANCEL_INV=0: 5 issues in order.
- Overflow, DEPTH=4: load 6 non-cancelling moves {R,U,F,L,B,D}. Expected: pending=4, overflow=1, issues 2,4,6,8 only.
- Pause: STREAM=1, assert pause mid-E_WAIT. Expected: the current move still completes; no further move_start while pause=1; resumes on deassert.
- Reset mid-move: reset during E_WAIT with 3 pending. Expected: all outputs at reset values next cycle; a later move_done does not increment executed.
- Back-to-back batches: second load_valid held during the scan. Expected: load_ready low for exactly 50 cycles, then the second batch accepted; order preserved across batches.
